path_stack: RTL and testbench

PATH_STACK -- requirements
Module: path_stack

---
 rtl/path_stack.sv | 186 ++++++++++++++++++
 tb/tb_path_stack.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/path_stack.sv
// ============================================================================
//  Module   : path_stack
//  Brief    : LIFO of move directions with a bottom-to-top streaming readout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module path_stack #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 256,
    parameter int PTR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              err,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic              r_err;
    logic [PTR_W-1:0]  r_idx;
    logic [PTR_W:0]    r_len;
    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_empty;
    logic              w_full;
    logic              w_busy;
    logic [PTR_W-1:0]  w_top;
    logic              w_we;
    logic [PTR_W-1:0]  w_waddr;
    logic [PTR_W:0]    w_count_nxt;
    logic              w_err_set;
    logic              w_dump_load;
    logic              w_idx_adv;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_busy  = (r_state != S_IDLE);
    // Low PTR_W bits of a full count are zero, so the subtraction wraps to DEPTH-1.
    assign w_top   = r_count[PTR_W-1:0] - c_PTR_ONE;

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign err   = r_err;
    assign busy  = w_busy;
    assign dout  = w_empty ? '0 : r_mem[w_top];

    // Stack operation decode
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_count[PTR_W-1:0];
        w_count_nxt = r_count;
        w_err_set   = 1'b0;
        if (w_busy) begin
            w_err_set = push | pop;
        end else if (push && pop) begin
            w_we = 1'b1;
            if (w_empty) begin
                w_waddr     = '0;
                w_count_nxt = c_CNT_ONE;
                w_err_set   = 1'b1;
            end else begin
                w_waddr = w_top;
            end
        end else if (push) begin
            if (w_full) begin
                w_err_set = 1'b1;
            end else begin
                w_we        = 1'b1;
                w_count_nxt = r_count + c_CNT_ONE;
            end
        end else if (pop) begin
            if (w_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_count_nxt = r_count - c_CNT_ONE;
            end
        end
    end

    // Readout FSM: next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_dump_load = 1'b0;
        w_idx_adv   = 1'b0;
        dump_valid  = 1'b0;
        dump_data   = '0;
        dump_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    if (w_empty) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_dump_load = 1'b1;
                        w_state_nxt = S_DUMP;
                    end
                end
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                dump_data  = r_mem[r_idx];
                if (dump_ready) begin
                    w_idx_adv = 1'b1;
                    if ({1'b0, r_idx} == (r_len - c_CNT_ONE)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                dump_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_len   <= '0;
        end else if (clr) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_dump_load) begin
                r_len <= r_count;
                r_idx <= '0;
            end else if (w_idx_adv) begin
                r_idx <= r_idx + c_PTR_ONE;
            end
        end
    end

    // Storage survives rst and clr; only a committed stack operation writes it.
    always_ff @(posedge clk) begin
        if (!rst && !clr && w_we) begin
            r_mem[w_waddr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_path_stack.sv
// ============================================================================
//  Module   : tb_path_stack
//  Brief    : Directed and random checks of path_stack against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_path_stack;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              err;
    logic              dump_start = 1'b0;
    logic              dump_ready = 1'b0;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;
    logic              busy;

    path_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: stack contents as a queue, readout as a snapshot list.
    int m_q[$];
    int m_snap[$];
    int m_mode = 0;      // 0 idle, 1 streaming, 2 finished
    int m_pos  = 0;
    int m_err  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int p, input int o, input int d,
                              input int c, input int ds, input int rdy, input int r);
        int was_busy;
        if (r != 0) begin
            m_q.delete(); m_err = 0; m_mode = 0; m_pos = 0;
        end else if (c != 0) begin
            m_q.delete(); m_err = 0; m_mode = 0;
        end else begin
            was_busy = (m_mode != 0);
            if (was_busy) begin
                if (p != 0 || o != 0) m_err = 1;
            end else if (p != 0 && o != 0) begin
                if (m_q.size() > 0) m_q[m_q.size()-1] = d;
                else begin m_q.push_back(d); m_err = 1; end
            end else if (p != 0) begin
                if (m_q.size() == DEPTH) m_err = 1;
                else m_q.push_back(d);
            end else if (o != 0) begin
                if (m_q.size() == 0) m_err = 1;
                else void'(m_q.pop_back());
            end
            if (m_mode == 0) begin
                if (ds != 0) begin
                    if (m_q.size() > 0) begin
                        m_snap = m_q; m_pos = 0; m_mode = 1;
                    end else begin
                        m_mode = 2;
                    end
                end
            end else if (m_mode == 1) begin
                if (rdy != 0) begin
                    if (m_pos == m_snap.size() - 1) m_mode = 2;
                    else m_pos++;
                end
            end else begin
                m_mode = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, compare #1 after the rising edge.
    task automatic step(input int p, input int o, input int d,
                        input int c, input int ds, input int rdy, input int r);
        @(negedge clk);
        push       = (p != 0);
        pop        = (o != 0);
        din        = DATA_W'(d);
        clr        = (c != 0);
        dump_start = (ds != 0);
        dump_ready = (rdy != 0);
        rst        = (r != 0);
        model_step(p, o, d, c, ds, rdy, r);
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full",  32'(full),  32'(m_q.size() == DEPTH));
        chk("dout",  32'(dout),  (m_q.size() > 0) ? 32'(m_q[m_q.size()-1]) : 32'd0);
        chk("err",   32'(err),   32'(m_err));
        chk("busy",  32'(busy),  32'(m_mode != 0));
        chk("dump_valid", 32'(dump_valid), 32'(m_mode == 1));
        chk("dump_data",  32'(dump_data),  (m_mode == 1) ? 32'(m_snap[m_pos]) : 32'd0);
        chk("dump_done",  32'(dump_done),  32'(m_mode == 2));
    endtask

    task automatic do_rst();  step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic do_push(input int d); step(1, 0, d, 0, 0, 0, 0); endtask

    initial begin
        int p, o, c, ds, r;

        // Reset state
        do_rst();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout",  32'(dout),  32'd0);

        // Fill to full, then overflow
        do_push(1); do_push(2); do_push(3); do_push(0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_dout",  32'(dout),  32'd0);
        do_push(2);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_err",   32'(err),   32'd1);
        chk("ovf_dout",  32'(dout),  32'd0);

        // Underflow then clr
        do_rst();
        step(0, 1, 0, 0, 0, 0, 0);
        chk("udf_err", 32'(err), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("clr_err", 32'(err), 32'd0);

        // Replace on partial and on full stack
        do_rst();
        do_push(1); do_push(2);
        step(1, 1, 3, 0, 0, 0, 0);
        chk("rep_count", 32'(count), 32'd2);
        chk("rep_dout",  32'(dout),  32'd3);
        chk("rep_err",   32'(err),   32'd0);
        do_push(1); do_push(2);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("repf_count", 32'(count), 32'd4);
        chk("repf_dout",  32'(dout),  32'd1);
        chk("repf_err",   32'(err),   32'd0);
        // Push+pop on empty acts as a push and flags an error
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_err",   32'(err),   32'd1);

        // Readout with backpressure
        do_rst();
        do_push(1); do_push(2); do_push(3);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("dump_first", 32'(dump_data), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dump_hold", 32'(dump_data), 32'd2);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("dump_done_pulse", 32'(dump_done), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dump_end_busy",  32'(busy),  32'd0);
        chk("dump_end_count", 32'(count), 32'd3);

        // Push while busy; empty readout
        do_rst();
        do_push(1); do_push(2);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0);
        chk("busy_push_count", 32'(count), 32'd2);
        chk("busy_push_err",   32'(err),   32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("empty_dump_done",  32'(dump_done),  32'd1);
        chk("empty_dump_valid", 32'(dump_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-dump
        do_push(1); do_push(2); do_push(3);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("mid_idx1", 32'(dump_data), 32'd2);
        do_rst();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(dump_done), 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("mid_rst_nodone", 32'(dump_done), 32'd0);

        // Random traffic; dump_start is only issued without a same-cycle push/pop
        for (int i = 0; i < 800; i++) begin
            p  = ($urandom_range(0, 99) < 45) ? 1 : 0;
            o  = ($urandom_range(0, 99) < 35) ? 1 : 0;
            c  = ($urandom_range(0, 99) < 3)  ? 1 : 0;
            r  = ($urandom_range(0, 99) < 2)  ? 1 : 0;
            ds = ($urandom_range(0, 99) < 12) ? 1 : 0;
            if (ds != 0) begin
                p = 0;
                o = 0;
            end
            step(p, o, int'($urandom_range(0, 3)), c, ds, int'($urandom_range(0, 1)), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
